// File: rtl/id_scoreboard_if.sv
// Decode/issue handshake and WB release bundle for the register scoreboard.
// master = decode side, slave = scoreboard.
interface id_scoreboard_if #(
    parameter int AW = 5,
    parameter int BW = 3
);
    logic          ds_valid;
    logic          es_allowin;
    logic          src1_en;
    logic [AW-1:0] src1_addr;
    logic          src2_en;
    logic [AW-1:0] src2_addr;
    logic          dst_en;
    logic [AW-1:0] dst_addr;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic          flush;
    logic          issue_go;
    logic [BW-1:0] busy_cnt;
    logic          sb_err;

    modport master (
        output ds_valid, es_allowin,
        output src1_en, src1_addr,
        output src2_en, src2_addr,
        output dst_en, dst_addr,
        output wb_we, wb_addr, flush,
        input  issue_go, busy_cnt, sb_err
    );

    modport slave (
        input  ds_valid, es_allowin,
        input  src1_en, src1_addr,
        input  src2_en, src2_addr,
        input  dst_en, dst_addr,
        input  wb_we, wb_addr, flush,
        output issue_go, busy_cnt, sb_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard and issue interlock (no forwarding).
// Optional ID_SB_WB_BYPASS_EN: waive a hazard whose last pending write retires this cycle.
module id_scoreboard #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int BW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    id_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
    localparam logic [BW-1:0]    TMAX = BW'(MAX_INFLIGHT);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [BW-1:0]    r_tot;
    logic             r_err;

    logic [CNT_W-1:0] w_c1;
    logic [CNT_W-1:0] w_c2;
    logic [CNT_W-1:0] w_cd;
    logic [CNT_W-1:0] w_cw;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw_sat;
    logic             w_full;
    logic             w_go;
    logic             w_issue;
    logic             w_inc;
    logic             w_dec;
    logic             w_wb_nz;
    logic             w_wb_miss;

    assign w_c1 = r_cnt[sb.src1_addr];
    assign w_c2 = r_cnt[sb.src2_addr];
    assign w_cd = r_cnt[sb.dst_addr];
    assign w_cw = r_cnt[sb.wb_addr];

`ifdef ID_SB_WB_BYPASS_EN
    // Decode takes this operand from the WB bus instead of the regfile.
    assign w_byp1 = sb.wb_we && (sb.wb_addr == sb.src1_addr) && (w_c1 == CONE);
    assign w_byp2 = sb.wb_we && (sb.wb_addr == sb.src2_addr) && (w_c2 == CONE);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        w_raw1    = sb.src1_en && (sb.src1_addr != '0)
                    && (w_c1 != '0) && !w_byp1;
        w_raw2    = sb.src2_en && (sb.src2_addr != '0)
                    && (w_c2 != '0) && !w_byp2;
        w_waw_sat = sb.dst_en && (sb.dst_addr != '0) && (w_cd == CMAX);
        w_full    = sb.dst_en && (sb.dst_addr != '0) && (r_tot == TMAX);
        w_go      = !sb.flush && !w_raw1 && !w_raw2
                    && !w_waw_sat && !w_full;
    end

    assign w_issue   = sb.ds_valid && w_go && sb.es_allowin;
    assign w_inc     = w_issue && sb.dst_en && (sb.dst_addr != '0);
    assign w_wb_nz   = sb.wb_we && (sb.wb_addr != '0);
    assign w_dec     = w_wb_nz && (w_cw != '0);
    assign w_wb_miss = w_wb_nz && (w_cw == '0);

    // r0 is never selected by inc/dec, so its counter stays zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_tot <= '0;
            r_err <= 1'b0;
        end else if (sb.flush) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_tot <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_inc && (sb.dst_addr == AW'(i))
                    && !(w_dec && (sb.wb_addr == AW'(i))))
                    r_cnt[i] <= r_cnt[i] + CONE;
                else if (w_dec && (sb.wb_addr == AW'(i))
                    && !(w_inc && (sb.dst_addr == AW'(i))))
                    r_cnt[i] <= r_cnt[i] - CONE;
            end
            if (w_inc && !w_dec)
                r_tot <= r_tot + BW'(1);
            else if (w_dec && !w_inc)
                r_tot <= r_tot - BW'(1);
            if (w_wb_miss)
                r_err <= 1'b1;
        end
    end

    assign sb.issue_go = w_go;
    assign sb.busy_cnt = r_tot;
    assign sb.sb_err   = r_err;
endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized self-checking bench for id_scoreboard against a per-register pending-count model.
module tb_id_scoreboard;
`ifdef ID_SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    int   m_cnt [32];
    int   m_tot;
    bit   m_err;

    id_scoreboard_if #(.AW(5), .BW(3)) sbif ();

    id_scoreboard dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_tot = 0;
    endtask

    function automatic bit m_haz(bit en, int a, bit we, int wa);
        if (!en || a == 0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && m_cnt[a] == 1 && we && wa == a) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: drive at negedge, check against model, advance model.
    task automatic cyc(input bit v, input bit al,
                       input bit e1, input int a1,
                       input bit e2, input int a2,
                       input bit ed, input int ad,
                       input bit we, input int wa,
                       input bit fl);
        bit go;
        bit inc;
        bit dec;
        @(negedge clk);
        sbif.ds_valid   = v;
        sbif.es_allowin = al;
        sbif.src1_en    = e1;
        sbif.src1_addr  = 5'(a1);
        sbif.src2_en    = e2;
        sbif.src2_addr  = 5'(a2);
        sbif.dst_en     = ed;
        sbif.dst_addr   = 5'(ad);
        sbif.wb_we      = we;
        sbif.wb_addr    = 5'(wa);
        sbif.flush      = fl;
        #1;
        go = !fl && !m_haz(e1, a1, we, wa) && !m_haz(e2, a2, we, wa)
             && !(ed && ad != 0 && m_cnt[ad] == 3)
             && !(ed && ad != 0 && m_tot == 4);
        chk("issue_go", int'(sbif.issue_go), int'(go));
        chk("busy_cnt", int'(sbif.busy_cnt), m_tot);
        chk("sb_err", int'(sbif.sb_err), int'(m_err));
        if (fl) begin
            m_clear();
        end else begin
            inc = v && al && go && ed && ad != 0;
            dec = we && wa != 0 && m_cnt[wa] != 0;
            if (we && wa != 0 && m_cnt[wa] == 0) m_err = 1'b1;
            if (inc) begin m_cnt[ad]++; m_tot++; end
            if (dec) begin m_cnt[wa]--; m_tot--; end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_clear();
        m_err = 1'b0;
        sbif.ds_valid = 0; sbif.es_allowin = 0;
        sbif.src1_en = 0; sbif.src1_addr = '0;
        sbif.src2_en = 0; sbif.src2_addr = '0;
        sbif.dst_en = 0; sbif.dst_addr = '0;
        sbif.wb_we = 0; sbif.wb_addr = '0;
        sbif.flush = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_busy", int'(sbif.busy_cnt), 0);
        chk("rst_err", int'(sbif.sb_err), 0);
        chk("rst_go", int'(sbif.issue_go), 1);

        // RAW stall released by WB
        cyc(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", int'(sbif.issue_go), 0);
        cyc(1, 0, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_release", int'(sbif.issue_go), 1);
        chk("raw_busy0", int'(sbif.busy_cnt), 0);

        // same-cycle WB on a source
        cyc(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 1, 5, 0);
        chk("wb_same_cyc", int'(sbif.issue_go), int'(BYP));

        // r0 never tracked
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
            chk("r0_go", int'(sbif.issue_go), 1);
            chk("r0_busy", int'(sbif.busy_cnt), 0);
        end

        // inc+dec same reg, then retire of idle reg
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        idle();
        chk("net_busy", int'(sbif.busy_cnt), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle();
        chk("err_set", int'(sbif.sb_err), 1);
        chk("err_busy", int'(sbif.busy_cnt), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // in-flight limit and flush
        for (int r = 1; r <= 4; r++) cyc(1, 1, 0, 0, 0, 0, 1, r, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        chk("full_stall", int'(sbif.issue_go), 0);
        chk("full_busy", int'(sbif.busy_cnt), 4);
        cyc(1, 1, 0, 0, 0, 0, 1, 6, 0, 0, 1);
        idle();
        chk("flush_busy", int'(sbif.busy_cnt), 0);
        chk("flush_go", int'(sbif.issue_go), 1);

        // WAW saturation on one register
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("waw_sat", int'(sbif.issue_go), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic on a small register window
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                @(negedge clk);
                #2;
                resetn = 1'b0;
                #1;
                m_clear();
                m_err = 1'b0;
                chk("async_busy", int'(sbif.busy_cnt), 0);
                chk("async_err", int'(sbif.sb_err), 0);
                @(posedge clk);
                #1;
                resetn = 1'b1;
            end
            cyc($urandom_range(3) != 0, $urandom_range(3) != 0,
                $urandom_range(1) == 1, int'($urandom_range(7)),
                $urandom_range(1) == 1, int'($urandom_range(7)),
                $urandom_range(3) != 0, int'($urandom_range(7)),
                $urandom_range(2) == 0, int'($urandom_range(7)),
                $urandom_range(60) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
